inst_prefetch_buffer: RTL and testbench

Sequential instruction prefetch queue between the RV32E core fetch port and instruction_cache_controller. It drives cache lookups at consecutive word addresses ahead of the core and stores returned words with their PCs in a DEPTH-entry FIFO. The core consumes the FIFO through a valid/ready handshake. A core redirect (branch, jump or trap) flushes the queue and restarts fetch, discarding any in-flight cache response.

---
 rtl/inst_prefetch_buffer_if.sv | 42 ++++
 rtl/inst_prefetch_buffer.sv | 115 +++++++++++
 tb/tb_inst_prefetch_buffer.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_prefetch_buffer_if.sv
// Fetch-side and cache-side signal bundle of the instruction prefetch queue.
// master = the prefetch buffer, slave = core/cache side.
interface inst_prefetch_buffer_if #(
    parameter int AW = 32
) ();
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          fetch_valid;
    logic          fetch_ready;
    logic [31:0]   fetch_inst;
    logic [AW-1:0] fetch_pc;
    logic          cache_req;
    logic [AW-1:0] cache_addr;
    logic [31:0]   cache_data;
    logic          cache_ready;

    modport master (
        input  redirect_valid,
        input  redirect_pc,
        output fetch_valid,
        input  fetch_ready,
        output fetch_inst,
        output fetch_pc,
        output cache_req,
        output cache_addr,
        input  cache_data,
        input  cache_ready
    );

    modport slave (
        output redirect_valid,
        output redirect_pc,
        input  fetch_valid,
        output fetch_ready,
        input  fetch_inst,
        input  fetch_pc,
        input  cache_req,
        input  cache_addr,
        output cache_data,
        output cache_ready
    );
endinterface

// File: rtl/inst_prefetch_buffer.sv
// Sequential instruction prefetch queue: issues word lookups ahead of the
// core and buffers {pc, inst} in a DEPTH-entry FIFO; redirects flush it.
module inst_prefetch_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic                          HCLK,
    input  logic                          HRESET,
    input  logic [AW-1:0]                 boot_addr,
    inst_prefetch_buffer_if.master        bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DROP
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] next_pc_q, next_pc_d;
    logic [AW-1:0] cache_addr_q, cache_addr_d;
    logic          cache_req_q;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [PW-1:0] wptr_q, wptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] pc_q   [DEPTH];
    logic [31:0]   inst_q [DEPTH];

    logic redir;
    logic push;
    logic pop;
    logic has_room;

    always_comb begin
        redir     = bus.redirect_valid;
        push      = (state_q == FETCH) && bus.cache_ready && !redir;
        pop       = (count_q != '0) && bus.fetch_ready && !redir;
        count_d   = count_q;
        rptr_d    = rptr_q;
        wptr_d    = wptr_q;
        next_pc_d = next_pc_q;
        state_d   = state_q;
        if (redir) begin
            count_d   = '0;
            rptr_d    = '0;
            wptr_d    = '0;
            next_pc_d = bus.redirect_pc & ~AW'(3);
        end else begin
            if (push) begin
                wptr_d    = wptr_q + PW'(1);
                next_pc_d = next_pc_q + AW'(4);
            end
            if (pop) begin
                rptr_d = rptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
        has_room = count_d < DEPTH_C;
        unique case (state_q)
            IDLE: begin
                if (redir || has_room) state_d = FETCH;
            end
            FETCH: begin
                if (bus.cache_ready) begin
                    state_d = (redir || has_room) ? FETCH : IDLE;
                end else if (redir) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (bus.cache_ready) state_d = FETCH;
            end
            default: state_d = IDLE;
        endcase
        // A stale lookup keeps its address until the cache answers it
        cache_addr_d = (state_d == DROP) ? cache_addr_q : next_pc_d;
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q      <= IDLE;
            next_pc_q    <= boot_addr & ~AW'(3);
            cache_addr_q <= boot_addr & ~AW'(3);
            cache_req_q  <= 1'b0;
            rptr_q       <= '0;
            wptr_q       <= '0;
            count_q      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= '0;
                inst_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            next_pc_q    <= next_pc_d;
            cache_addr_q <= cache_addr_d;
            cache_req_q  <= (state_d != IDLE);
            rptr_q       <= rptr_d;
            wptr_q       <= wptr_d;
            count_q      <= count_d;
            if (push) begin
                pc_q[wptr_q]   <= next_pc_q;
                inst_q[wptr_q] <= bus.cache_data;
            end
        end
    end

    assign bus.fetch_valid = (count_q != '0);
    assign bus.fetch_inst  = inst_q[rptr_q];
    assign bus.fetch_pc    = pc_q[rptr_q];
    assign bus.cache_req   = cache_req_q;
    assign bus.cache_addr  = cache_addr_q;
endmodule

// File: tb/tb_inst_prefetch_buffer.sv
// Bench for inst_prefetch_buffer: cache model with per-address miss
// latency, expected-PC scoreboard checked on every core pop.
module tb_inst_prefetch_buffer;
    logic        clk = 1'b0;
    logic        HRESET;
    logic [31:0] boot_addr;

    inst_prefetch_buffer_if #(.AW(32)) bus ();

    inst_prefetch_buffer #(.DEPTH(4), .AW(32)) dut (
        .HCLK     (clk),
        .HRESET   (HRESET),
        .boot_addr(boot_addr),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q[$];
    logic [31:0] miss_addr = 32'h0;
    int          miss_lat  = 0;
    int          n_done    = 0;

    typedef struct {
        logic [31:0] boot;
        int          npop;
        logic [31:0] exp_addr;
        int          exp_lat;
    } vec_t;

    vec_t vecs [4];

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], ~a[31:16]};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    // Cache model: answers after miss_lat wait cycles on miss_addr, else hits
    logic [31:0] cur_addr  = 32'h0;
    int          wcnt      = 0;
    logic        done_last = 1'b0;
    always @(negedge clk) begin
        int lat;
        if (bus.cache_req) begin
            if (bus.cache_addr != cur_addr || done_last) begin
                cur_addr = bus.cache_addr;
                wcnt     = 0;
            end
            lat = (miss_lat != 0 && bus.cache_addr == miss_addr) ? miss_lat : 0;
            bus.cache_ready = (wcnt >= lat);
            bus.cache_data  = inst_of(bus.cache_addr);
            wcnt++;
            done_last = bus.cache_ready;
        end else begin
            bus.cache_ready = 1'b0;
            done_last       = 1'b0;
            wcnt            = 0;
        end
    end

    always @(posedge clk) begin
        if (!HRESET && bus.cache_req && bus.cache_ready) n_done++;
    end

    always @(negedge clk) begin
        logic [31:0] e;
        if (!HRESET && bus.fetch_valid && bus.fetch_ready
            && !bus.redirect_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pop", {32'h0, bus.fetch_pc}, 64'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("fetch_pc", {32'h0, bus.fetch_pc}, {32'h0, e});
                chk("fetch_inst", {32'h0, bus.fetch_inst}, {32'h0, inst_of(e)});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset(input logic [31:0] b);
        @(posedge clk);
        #1;
        HRESET             = 1'b1;
        boot_addr          = b;
        bus.redirect_valid = 1'b0;
        bus.fetch_ready    = 1'b0;
        miss_lat           = 0;
        exp_q.delete();
        @(posedge clk);
    endtask

    task automatic release_rst();
        @(posedge clk);
        #1;
        HRESET = 1'b0;
    endtask

    task automatic push_seq(input logic [31:0] a, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(a + 32'(4 * i));
    endtask

    task automatic drain(input int bound, input string nm);
        bit ok = 1'b0;
        for (int k = 0; k < bound; k++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        bus.fetch_ready = 1'b0;
        chk(nm, {63'h0, ok}, 64'h1);
        exp_q.delete();
    endtask

    task automatic wait_addr(input logic [31:0] a, input int bound,
                             input string nm);
        bit ok = 1'b0;
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (bus.cache_addr == a) begin
                ok = 1'b1;
                break;
            end
        end
        chk(nm, {63'h0, ok}, 64'h1);
    endtask

    initial begin
        int lat;
        int base;
        bit seen;
        vecs[0] = '{32'h0000_0100, 6, 32'h0000_0100, 2};
        vecs[1] = '{32'hFFFF_FFF8, 4, 32'hFFFF_FFF8, 2};
        vecs[2] = '{32'h0000_0203, 5, 32'h0000_0200, 2};
        vecs[3] = '{32'h8000_0006, 3, 32'h8000_0004, 2};

        HRESET             = 1'b1;
        boot_addr          = 32'h0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.fetch_ready    = 1'b0;
        bus.cache_ready    = 1'b0;
        bus.cache_data     = 32'h0;

        // Reset values, first-fetch latency, sequential stream incl. wrap
        foreach (vecs[v]) begin
            do_reset(vecs[v].boot);
            @(negedge clk);
            chk("rst_fetch_valid", {63'h0, bus.fetch_valid}, 64'h0);
            chk("rst_cache_req", {63'h0, bus.cache_req}, 64'h0);
            chk("rst_cache_addr", {32'h0, bus.cache_addr}, {32'h0, vecs[v].exp_addr});
            chk("rst_fetch_inst", {32'h0, bus.fetch_inst}, 64'h0);
            chk("rst_fetch_pc", {32'h0, bus.fetch_pc}, 64'h0);
            release_rst();
            lat = 0;
            for (int k = 1; k <= 20; k++) begin
                @(posedge clk);
                @(negedge clk);
                if (bus.fetch_valid) begin
                    lat = k;
                    break;
                end
            end
            chk("first_valid_latency", 64'(lat), 64'(vecs[v].exp_lat));
            @(posedge clk);
            #1;
            push_seq(vecs[v].exp_addr, vecs[v].npop);
            bus.fetch_ready = 1'b1;
            drain(vecs[v].npop * 4 + 20, "stream_drain");
        end

        // Backpressure: four pushes then IDLE; one pop re-arms fetch
        do_reset(32'h0000_0100);
        base = n_done;
        release_rst();
        repeat (12) @(posedge clk);
        @(negedge clk);
        chk("full_lookups", 64'(n_done - base), 64'd4);
        chk("full_cache_req", {63'h0, bus.cache_req}, 64'h0);
        chk("full_head_pc", {32'h0, bus.fetch_pc}, 64'h100);
        @(posedge clk);
        #1;
        exp_q.push_back(32'h0000_0100);
        bus.fetch_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.fetch_ready = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("rearm_lookups", 64'(n_done - base), 64'd5);
        chk("rearm_cache_req", {63'h0, bus.cache_req}, 64'h0);
        @(posedge clk);
        #1;
        push_seq(32'h0000_0104, 4);
        bus.fetch_ready = 1'b1;
        drain(30, "rearm_drain");

        // Redirect while the 0x108 lookup misses
        do_reset(32'h0000_0100);
        miss_addr = 32'h0000_0108;
        miss_lat  = 10;
        push_seq(32'h0000_0100, 2);
        push_seq(32'h0000_2000, 3);
        bus.fetch_ready = 1'b1;
        release_rst();
        wait_addr(32'h0000_0108, 20, "miss_reached");
        repeat (3) @(posedge clk);
        #1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_2002;
        @(posedge clk);
        #1;
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        chk("drop_addr_held", {32'h0, bus.cache_addr}, 64'h108);
        chk("drop_cache_req", {63'h0, bus.cache_req}, 64'h1);
        chk("drop_fetch_valid", {63'h0, bus.fetch_valid}, 64'h0);
        repeat (3) @(negedge clk);
        chk("drop_addr_still", {32'h0, bus.cache_addr}, 64'h108);
        wait_addr(32'h0000_2000, 30, "refetch_addr");
        drain(40, "redirect_miss_drain");

        // Redirect coinciding with a hit on 0x10C and a core pop
        do_reset(32'h0000_0100);
        push_seq(32'h0000_0100, 2);
        push_seq(32'h0000_3000, 2);
        bus.fetch_ready = 1'b1;
        release_rst();
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (bus.cache_addr == 32'h0000_010C) begin
                seen = 1'b1;
                bus.redirect_valid = 1'b1;
                bus.redirect_pc    = 32'h0000_3000;
                break;
            end
        end
        chk("hit_10c_reached", {63'h0, seen}, 64'h1);
        @(posedge clk);
        #1;
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        chk("redir_fetch_valid", {63'h0, bus.fetch_valid}, 64'h0);
        chk("redir_cache_addr", {32'h0, bus.cache_addr}, 64'h3000);
        chk("redir_cache_req", {63'h0, bus.cache_req}, 64'h1);
        drain(20, "redirect_hit_drain");

        // Reset during a miss with three entries queued
        do_reset(32'h0000_0100);
        base      = n_done;
        miss_addr = 32'h0000_010C;
        miss_lat  = 50;
        release_rst();
        wait_addr(32'h0000_010C, 20, "miss3_reached");
        chk("miss3_lookups", 64'(n_done - base), 64'd3);
        chk("miss3_fetch_valid", {63'h0, bus.fetch_valid}, 64'h1);
        do_reset(32'h0000_0500);
        @(negedge clk);
        chk("rst_mid_fetch_valid", {63'h0, bus.fetch_valid}, 64'h0);
        chk("rst_mid_cache_req", {63'h0, bus.cache_req}, 64'h0);
        chk("rst_mid_cache_addr", {32'h0, bus.cache_addr}, 64'h500);
        push_seq(32'h0000_0500, 3);
        bus.fetch_ready = 1'b1;
        release_rst();
        drain(30, "rst_mid_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
